// File: rtl/bcd_stopwatch_if.sv
// Signal bundle for bcd_stopwatch: run/mode/preset/lap controls in, packed-BCD time and status out.
interface bcd_stopwatch_if;
    logic       RUN;
    logic       DOWN;
    logic       LOAD;
    logic [7:0] MIN_IN;
    logic [7:0] SEC_IN;
    logic       LAP;
    logic [7:0] Q_MIN;
    logic [7:0] Q_SEC;
    logic [7:0] Q_CS;
    logic [7:0] LAP_MIN;
    logic [7:0] LAP_SEC;
    logic [7:0] LAP_CS;
    logic       LAP_VALID;
    logic       TICK;
    logic       WRAP;
    logic       DONE;

    modport master (
        output RUN, DOWN, LOAD, MIN_IN, SEC_IN, LAP,
        input  Q_MIN, Q_SEC, Q_CS, LAP_MIN, LAP_SEC, LAP_CS, LAP_VALID, TICK, WRAP, DONE
    );

    modport slave (
        input  RUN, DOWN, LOAD, MIN_IN, SEC_IN, LAP,
        output Q_MIN, Q_SEC, Q_CS, LAP_MIN, LAP_SEC, LAP_CS, LAP_VALID, TICK, WRAP, DONE
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// MM:SS.cc packed-BCD stopwatch/timer with up/down count, clamped preset load, expiry and wrap.
// Lap capture registers exist only when STOPWATCH_LAP_EN is defined.
//
//   state   | meaning
//   STOPPED | paused; prescaler and time hold
//   RUNNING | prescaler advancing, time steps each DIV cycles
//   EXPIRED | down-count hit zero; frozen until LOAD or RST
module bcd_stopwatch #(
    parameter int unsigned DIV     = 500000,
    parameter logic [7:0]  MAX_MIN = 8'h59
) (
    input logic            CLK,
    input logic            RST,
    bcd_stopwatch_if.slave sw
);
    localparam int unsigned   PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    q_min, q_sec, q_cs;
    logic          tick, wrap, done;

    logic [7:0] up_min, up_sec, up_cs, dn_min, dn_sec, dn_cs, ld_min, ld_sec;
    logic       up_wrap, time_zero, dn_zero;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {(v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    always_comb begin
        up_cs   = bcd_inc(q_cs);
        up_sec  = q_sec;
        up_min  = q_min;
        up_wrap = 1'b0;
        if (q_cs == 8'h99) begin
            if (q_sec == 8'h59) begin
                up_sec = 8'h00;
                if (q_min >= MAX_MIN) begin
                    up_min  = 8'h00;
                    up_wrap = 1'b1;
                end else begin
                    up_min = bcd_inc(q_min);
                end
            end else begin
                up_sec = bcd_inc(q_sec);
            end
        end

        // Minute underflow only reachable from 00:00.00, which expires before decrementing.
        dn_cs  = bcd_dec(q_cs);
        dn_sec = q_sec;
        dn_min = q_min;
        if (q_cs == 8'h00) begin
            if (q_sec == 8'h00) begin
                dn_sec = 8'h59;
                dn_min = (q_min == 8'h00) ? MAX_MIN : bcd_dec(q_min);
            end else begin
                dn_sec = bcd_dec(q_sec);
            end
        end

        time_zero = (q_min == 8'h00) && (q_sec == 8'h00) && (q_cs == 8'h00);
        dn_zero   = (dn_min == 8'h00) && (dn_sec == 8'h00) && (dn_cs == 8'h00);

        ld_min = {clamp_digit(sw.MIN_IN[7:4], 4'd9), clamp_digit(sw.MIN_IN[3:0], 4'd9)};
        if (ld_min > MAX_MIN)
            ld_min = MAX_MIN;
        ld_sec = {clamp_digit(sw.SEC_IN[7:4], 4'd5), clamp_digit(sw.SEC_IN[3:0], 4'd9)};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= STOPPED;
            presc <= '0;
            q_min <= 8'h00;
            q_sec <= 8'h00;
            q_cs  <= 8'h00;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else if (sw.LOAD) begin
            state <= STOPPED;
            presc <= '0;
            q_min <= ld_min;
            q_sec <= ld_sec;
            q_cs  <= 8'h00;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            case (state)
                STOPPED, RUNNING: begin
                    if (!sw.RUN) begin
                        state <= STOPPED;
                    end else if (sw.DOWN && time_zero) begin
                        state <= EXPIRED;
                        done  <= 1'b1;
                    end else begin
                        state <= RUNNING;
                        if (presc == PS_LAST) begin
                            presc <= '0;
                            tick  <= 1'b1;
                            if (sw.DOWN) begin
                                q_min <= dn_min;
                                q_sec <= dn_sec;
                                q_cs  <= dn_cs;
                                if (dn_zero) begin
                                    state <= EXPIRED;
                                    done  <= 1'b1;
                                end
                            end else begin
                                q_min <= up_min;
                                q_sec <= up_sec;
                                q_cs  <= up_cs;
                                wrap  <= up_wrap;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end
                EXPIRED: state <= EXPIRED;
                default: state <= STOPPED;
            endcase
        end
    end

    assign sw.Q_MIN = q_min;
    assign sw.Q_SEC = q_sec;
    assign sw.Q_CS  = q_cs;
    assign sw.TICK  = tick;
    assign sw.WRAP  = wrap;
    assign sw.DONE  = done;

`ifdef STOPWATCH_LAP_EN
    logic [7:0] lap_min, lap_sec, lap_cs;
    logic       lap_valid;

    // Captures the time held before this edge, so a coincident tick is not seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lap_min   <= 8'h00;
            lap_sec   <= 8'h00;
            lap_cs    <= 8'h00;
            lap_valid <= 1'b0;
        end else if (sw.LOAD) begin
            lap_valid <= 1'b0;
        end else if (sw.LAP) begin
            lap_min   <= q_min;
            lap_sec   <= q_sec;
            lap_cs    <= q_cs;
            lap_valid <= 1'b1;
        end
    end

    assign sw.LAP_MIN   = lap_min;
    assign sw.LAP_SEC   = lap_sec;
    assign sw.LAP_CS    = lap_cs;
    assign sw.LAP_VALID = lap_valid;
`else
    logic unused_lap;
    assign unused_lap   = sw.LAP;
    assign sw.LAP_MIN   = 8'h00;
    assign sw.LAP_SEC   = 8'h00;
    assign sw.LAP_CS    = 8'h00;
    assign sw.LAP_VALID = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch (DIV=4, MAX_MIN=59): stimulus queues expected ticks, a monitor checks them.
module tb_bcd_stopwatch;
    localparam int DIV = 4;

    typedef struct {
        int         cyc;
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] cs;
        logic       wrap;
        logic       done;
    } exp_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n_tick;
    int   m_min, m_sec, m_cs;
    int   c;
    exp_t exp_q[$];

    bcd_stopwatch_if sw();

    bcd_stopwatch #(.DIV(DIV), .MAX_MIN(8'h59)) dut (
        .CLK (CLK),
        .RST (RST),
        .sw  (sw)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc++;

    function automatic logic [7:0] i2b(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_up(input int n, input int first_cyc);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            bit   w;
            w = 1'b0;
            m_cs++;
            if (m_cs == 100) begin
                m_cs = 0;
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    m_min++;
                    if (m_min > 59) begin
                        m_min = 0;
                        w = 1'b1;
                    end
                end
            end
            e.cyc = first_cyc + DIV * k;
            e.min = i2b(m_min);
            e.sec = i2b(m_sec);
            e.cs = i2b(m_cs);
            e.wrap = w;
            e.done = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_down(input int n, input int first_cyc);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            if (m_cs > 0) begin
                m_cs--;
            end else begin
                m_cs = 99;
                if (m_sec > 0) begin
                    m_sec--;
                end else begin
                    m_sec = 59;
                    m_min--;
                end
            end
            e.cyc = first_cyc + DIV * k;
            e.min = i2b(m_min);
            e.sec = i2b(m_sec);
            e.cs = i2b(m_cs);
            e.wrap = 1'b0;
            e.done = (m_min == 0 && m_sec == 0 && m_cs == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q_min"}, sw.Q_MIN, 0);
        chk({tag, "_q_sec"}, sw.Q_SEC, 0);
        chk({tag, "_q_cs"}, sw.Q_CS, 0);
        chk({tag, "_lap_min"}, sw.LAP_MIN, 0);
        chk({tag, "_lap_sec"}, sw.LAP_SEC, 0);
        chk({tag, "_lap_cs"}, sw.LAP_CS, 0);
        chk({tag, "_lap_valid"}, sw.LAP_VALID, 0);
        chk({tag, "_tick"}, sw.TICK, 0);
        chk({tag, "_wrap"}, sw.WRAP, 0);
        chk({tag, "_done"}, sw.DONE, 0);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sw.TICK) begin
            n_tick++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick: TICK at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || sw.Q_MIN !== e.min || sw.Q_SEC !== e.sec || sw.Q_CS !== e.cs ||
                    sw.WRAP !== e.wrap || sw.DONE !== e.done) begin
                    n_fail++;
                    $display("FAIL tick_%0d: cycle %0d time %h:%h.%h wrap %b done %b, expected cycle %0d time %h:%h.%h wrap %b done %b",
                             n_tick, cyc, sw.Q_MIN, sw.Q_SEC, sw.Q_CS, sw.WRAP, sw.DONE,
                             e.cyc, e.min, e.sec, e.cs, e.wrap, e.done);
                end
            end
        end else if (sw.WRAP) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_without_tick: WRAP=1 TICK=0 at cycle %0d, expected WRAP only with TICK", cyc);
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        n_tests = 0;
        n_fail  = 0;
        n_tick  = 0;
        RST = 1'b1;
        sw.RUN = 1'b0;
        sw.DOWN = 1'b0;
        sw.LOAD = 1'b0;
        sw.LAP = 1'b0;
        sw.MIN_IN = 8'h00;
        sw.SEC_IN = 8'h00;
        step(2);
        check_all_zero("reset");
        RST = 1'b0;

        // Up count from zero: 100 ticks, BCD carries up to 00:01.00.
        m_min = 0; m_sec = 0; m_cs = 0;
        c = cyc;
        sw.RUN = 1'b1;
        push_up(100, c + DIV);
        step(400);
        sw.RUN = 1'b0;
        step(2);
        chk("up_sec", sw.Q_SEC, 8'h01);
        chk("up_cs", sw.Q_CS, 8'h00);
        chk("up_queue_empty", exp_q.size(), 0);

        // Pause with prescaler at 2 for 10 cycles, resume: tick after 2 cycles.
        c = cyc;
        sw.RUN = 1'b1;
        step(2);
        sw.RUN = 1'b0;
        step(10);
        push_up(1, c + 14);
        sw.RUN = 1'b1;
        step(2);
        sw.RUN = 1'b0;
        step(2);
        chk("pause_cs", sw.Q_CS, 8'h01);
        chk("pause_queue_empty", exp_q.size(), 0);

        // Rollover from 59:59.00 through 59:59.99 to 00:00.00 with WRAP.
        sw.MIN_IN = 8'h59;
        sw.SEC_IN = 8'h59;
        sw.LOAD = 1'b1;
        step(1);
        sw.LOAD = 1'b0;
        chk("load_min", sw.Q_MIN, 8'h59);
        chk("load_sec", sw.Q_SEC, 8'h59);
        chk("load_cs", sw.Q_CS, 8'h00);
        m_min = 59; m_sec = 59; m_cs = 0;
        c = cyc;
        sw.RUN = 1'b1;
        push_up(101, c + DIV);
        step(404);
        sw.RUN = 1'b0;
        step(2);
        chk("roll_wrap_low", sw.WRAP, 0);
        chk("roll_done", sw.DONE, 0);
        chk("roll_queue_empty", exp_q.size(), 0);

        // Down count from 00:01.00 to expiry, then frozen for 50 cycles.
        sw.DOWN = 1'b1;
        sw.MIN_IN = 8'h00;
        sw.SEC_IN = 8'h01;
        sw.LOAD = 1'b1;
        step(1);
        sw.LOAD = 1'b0;
        m_min = 0; m_sec = 1; m_cs = 0;
        c = cyc;
        sw.RUN = 1'b1;
        push_down(100, c + DIV);
        step(400);
        step(52);
        chk("down_done", sw.DONE, 1);
        chk("down_frozen_cs", sw.Q_CS, 0);
        chk("down_frozen_sec", sw.Q_SEC, 0);
        chk("down_queue_empty", exp_q.size(), 0);

        // Running down from an already-zero preset expires on the next edge without a tick.
        sw.SEC_IN = 8'h00;
        sw.LOAD = 1'b1;
        step(1);
        sw.LOAD = 1'b0;
        chk("zero_load_done_clr", sw.DONE, 0);
        step(1);
        chk("zero_expire_done", sw.DONE, 1);
        step(8);
        chk("zero_expire_hold", sw.DONE, 1);

        // Clamped preset.
        sw.RUN = 1'b0;
        sw.MIN_IN = 8'h7A;
        sw.SEC_IN = 8'h6F;
        sw.LOAD = 1'b1;
        step(1);
        sw.LOAD = 1'b0;
        sw.DOWN = 1'b0;
        chk("clamp_min", sw.Q_MIN, 8'h59);
        chk("clamp_sec", sw.Q_SEC, 8'h59);
        chk("clamp_cs", sw.Q_CS, 8'h00);
        chk("clamp_done", sw.DONE, 0);

        // Lap coincident with the 00:00.37 -> 00:00.38 tick, then lap together with load.
        sw.MIN_IN = 8'h00;
        sw.SEC_IN = 8'h00;
        sw.LOAD = 1'b1;
        step(1);
        sw.LOAD = 1'b0;
        m_min = 0; m_sec = 0; m_cs = 0;
        c = cyc;
        sw.RUN = 1'b1;
        push_up(38, c + DIV);
        step(151);
        sw.LAP = 1'b1;
        step(1);
        sw.LAP = 1'b0;
        chk("lap_q_cs_advanced", sw.Q_CS, 8'h38);
`ifdef STOPWATCH_LAP_EN
        chk("lap_cs", sw.LAP_CS, 8'h37);
        chk("lap_sec", sw.LAP_SEC, 8'h00);
        chk("lap_valid", sw.LAP_VALID, 1);
`else
        chk("lap_cs_off", sw.LAP_CS, 8'h00);
        chk("lap_valid_off", sw.LAP_VALID, 0);
`endif
        sw.LAP = 1'b1;
        sw.LOAD = 1'b1;
        sw.RUN = 1'b0;
        step(1);
        sw.LAP = 1'b0;
        sw.LOAD = 1'b0;
        chk("lap_load_valid", sw.LAP_VALID, 0);
        chk("lap_load_cs", sw.Q_CS, 8'h00);
        step(2);
        chk("lap_queue_empty", exp_q.size(), 0);

        // Reset mid-count from a non-zero time, then first tick DIV cycles after release.
        sw.MIN_IN = 8'h12;
        sw.SEC_IN = 8'h34;
        sw.LOAD = 1'b1;
        step(1);
        sw.LOAD = 1'b0;
        m_min = 12; m_sec = 34; m_cs = 0;
        c = cyc;
        sw.RUN = 1'b1;
        push_up(1, c + DIV);
        step(6);
        RST = 1'b1;
        step(1);
        check_all_zero("rst_mid");
        RST = 1'b0;
        m_min = 0; m_sec = 0; m_cs = 0;
        c = cyc;
        push_up(1, c + DIV);
        step(4);
        sw.RUN = 1'b0;
        step(2);
        chk("rst_restart_cs", sw.Q_CS, 8'h01);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
